waterfall_fb_ctrl: RTL

Framebuffer controller for the waterfall display: owns the single-port 8-bit pixel RAM and shares it between the LCD scan-out reader and the spectrum/ADC sample writer. It zero-clears the RAM after reset and writes incoming samples one row at a time, only while the LCD is outside the visible area. It commits each completed row at frame boundaries, so the display scrolls as a circular buffer with the newest row at the top. It sits between the `lcdtest` driver (`visible`, `x`, `y`, `lower_blank`), the sample source, and `ram`.

---
 rtl/waterfall_fb_ctrl_if.sv | 30 +++
 rtl/waterfall_fb_ctrl.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/waterfall_fb_ctrl_if.sv
// Signal bundle between the waterfall framebuffer controller and its
// environment (LCD timing, sample source and pixel RAM).
interface waterfall_fb_ctrl_if #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 8
);
    logic              visible;
    logic [8:0]        x;
    logic [7:0]        y;
    logic              lower_blank;
    logic              sample_valid;
    logic [DATA_W-1:0] sample_data;
    logic              sample_ready;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_we;
    logic [7:0]        row_base;
    logic              row_done;

    // master: the controller; slave: LCD driver, sample source and RAM side
    modport master (
        input  visible, x, y, lower_blank, sample_valid, sample_data,
        output sample_ready, ram_addr, ram_wdata, ram_we, row_base, row_done
    );

    modport slave (
        output visible, x, y, lower_blank, sample_valid, sample_data,
        input  sample_ready, ram_addr, ram_wdata, ram_we, row_base, row_done
    );
endinterface

// File: rtl/waterfall_fb_ctrl.sv
// Waterfall framebuffer controller: clears the pixel RAM, writes sample rows
// outside the visible area and scrolls the display as a circular row buffer.
module waterfall_fb_ctrl #(
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 240,
    parameter int ADDR_W = 17,
    parameter int DATA_W = 8
) (
    input logic                clk,
    input logic                reset,
    waterfall_fb_ctrl_if.master bus
);

    typedef enum logic [1:0] {
        CLEAR,
        FILL,
        WAIT_COMMIT
    } state_e;

    localparam int                PW        = ADDR_W + 10;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);
    localparam logic [8:0]        COL_LAST  = 9'(WIDTH - 1);
    localparam logic [7:0]        ROW_LAST  = 8'(HEIGHT - 1);
    localparam logic [8:0]        HEIGHT9   = 9'(HEIGHT);

    // Row start offset; the default 320-wide panel uses shift-add instead of a multiplier
    function automatic logic [PW-1:0] row_offset(input logic [PW-1:0] r);
        if (WIDTH == 320) begin
            return (r << 8) + (r << 6);
        end else begin
            return r * PW'(WIDTH);
        end
    endfunction

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
    logic [8:0]        col_q, col_d;
    logic [7:0]        write_row_q, write_row_d;
    logic [7:0]        row_base_q, row_base_d;
    logic              lb_q;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic              ram_we_q, ram_we_d;
    logic              row_done_q, row_done_d;

    logic [8:0]        phys_sum;
    logic [8:0]        phys;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] wr_addr;
    logic              ready;
    logic              xfer;
    logic              lb_rise;

    always_comb begin
        phys_sum = {1'b0, row_base_q} + {1'b0, bus.y};
        phys     = (phys_sum >= HEIGHT9) ? (phys_sum - HEIGHT9) : phys_sum;
        rd_addr  = ADDR_W'(row_offset(PW'(phys)) + PW'(bus.x));
        wr_addr  = ADDR_W'(row_offset(PW'(write_row_q)) + PW'(col_q));
    end

    assign ready   = (state_q == FILL) && !bus.visible;
    assign xfer    = ready && bus.sample_valid;
    assign lb_rise = bus.lower_blank && !lb_q;

    always_comb begin
        state_d     = state_q;
        clr_addr_d  = clr_addr_q;
        col_d       = col_q;
        write_row_d = write_row_q;
        row_base_d  = row_base_q;
        ram_addr_d  = '0;
        ram_wdata_d = '0;
        ram_we_d    = 1'b0;
        row_done_d  = 1'b0;

        // Display reads always win the RAM port
        if (bus.visible) begin
            ram_addr_d = rd_addr;
        end

        case (state_q)
            CLEAR: begin
                if (!bus.visible) begin
                    ram_addr_d = clr_addr_q;
                    ram_we_d   = 1'b1;
                    if (clr_addr_q == LAST_ADDR) begin
                        clr_addr_d = '0;
                        state_d    = FILL;
                    end else begin
                        clr_addr_d = clr_addr_q + 1'b1;
                    end
                end
            end

            FILL: begin
                if (xfer) begin
                    ram_addr_d  = wr_addr;
                    ram_wdata_d = bus.sample_data;
                    ram_we_d    = 1'b1;
                    if (col_q == COL_LAST) begin
                        col_d   = '0;
                        state_d = WAIT_COMMIT;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end

            WAIT_COMMIT: begin
                // Newest row becomes display row 0; the writer moves up one row
                if (lb_rise) begin
                    row_base_d  = write_row_q;
                    write_row_d = (write_row_q == '0) ? ROW_LAST : (write_row_q - 1'b1);
                    row_done_d  = 1'b1;
                    state_d     = FILL;
                end
            end

            default: begin
                state_d = CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= CLEAR;
            clr_addr_q  <= '0;
            col_q       <= '0;
            write_row_q <= ROW_LAST;
            row_base_q  <= '0;
            lb_q        <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_we_q    <= 1'b0;
            row_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_addr_q  <= clr_addr_d;
            col_q       <= col_d;
            write_row_q <= write_row_d;
            row_base_q  <= row_base_d;
            lb_q        <= bus.lower_blank;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ram_we_q    <= ram_we_d;
            row_done_q  <= row_done_d;
        end
    end

    assign bus.sample_ready = ready;
    assign bus.ram_addr     = ram_addr_q;
    assign bus.ram_wdata    = ram_wdata_q;
    assign bus.ram_we       = ram_we_q;
    assign bus.row_base     = row_base_q;
    assign bus.row_done     = row_done_q;

endmodule
